// File: rtl/wishbone_timer_slave.sv
// Wishbone B4 classic slave holding a prescaled 32-bit up-counter with compare match,
// auto-reload and a level interrupt. Single-cycle acknowledge, byte-lane writes.
module wishbone_timer_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    input  logic                  i_CYC,
    output logic                  o_ACK,
    input  logic                  i_TAGN,
    output logic                  o_TAGN,
    output logic                  o_IRQ
);

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_PRE  = 3'd1;
    localparam logic [2:0] A_CNT  = 3'd2;
    localparam logic [2:0] A_CMP  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] ps_q, ps_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tagn_q, tagn_d;

    logic [2:0]  idx;
    logic        acc;
    logic        wr;
    logic        tick;
    logic        hit;
    logic        cnt_wr;
    logic [31:0] lane_mask;
    logic [31:0] cur;
    logic [31:0] wm;
    logic        unused_addr;

    assign unused_addr = ^{i_ADDR[ADDR_WIDTH-1:5], i_ADDR[1:0]};

    assign o_ACK  = ack_q;
    assign o_DATA = rdata_q;
    assign o_TAGN = tagn_q;
    assign o_IRQ  = match_q & ctrl_q[2];

    always_comb begin
        idx       = i_ADDR[4:2];
        acc       = i_CYC & i_STB & ~ack_q;
        wr        = acc & i_WE;
        cnt_wr    = wr && (idx == A_CNT);
        tick      = ctrl_q[0] && (ps_q == prescale_q);
        hit       = (count_q == compare_q);
        lane_mask = {{8{i_SEL[3]}}, {8{i_SEL[2]}}, {8{i_SEL[1]}}, {8{i_SEL[0]}}};

        case (idx)
            A_CTRL:  cur = {29'd0, ctrl_q};
            A_PRE:   cur = {16'd0, prescale_q};
            A_CNT:   cur = count_q;
            A_CMP:   cur = compare_q;
            A_STAT:  cur = {31'd0, match_q};
            default: cur = 32'd0;
        endcase
        wm = (cur & ~lane_mask) | (i_DATA & lane_mask);

        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        match_d    = match_q;
        ack_d      = acc;
        rdata_d    = (acc && !i_WE) ? cur : 32'd0;
        tagn_d     = acc ? i_TAGN : tagn_q;

        if (!ctrl_q[0] || tick) begin
            ps_d = 16'd0;
        end else begin
            ps_d = ps_q + 16'd1;
        end

        // With AUTORELOAD the match cycle itself restarts from 0; otherwise plain wrap-around.
        if (tick) begin
            count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        if (wr) begin
            case (idx)
                A_CTRL: ctrl_d = wm[2:0];
                A_PRE: begin
                    prescale_d = wm[15:0];
                    ps_d       = 16'd0;
                end
                A_CNT:  count_d   = wm;
                A_CMP:  compare_d = wm;
                A_STAT: if (i_SEL[0] && i_DATA[0]) match_d = 1'b0;
                default: ;
            endcase
        end

        // A coincident bus write to COUNT swallows the tick, match included.
        if (tick && hit && !cnt_wr) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ctrl_q     <= 3'd0;
            prescale_q <= 16'd0;
            ps_q       <= 16'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            tagn_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            ps_q       <= ps_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            tagn_q     <= tagn_d;
        end
    end

endmodule

// File: tb/tb_wishbone_timer_slave.sv
// Directed and randomized bench for wishbone_timer_slave against a cycle-level
// behavioural model of the timer register file.
module tb_wishbone_timer_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        i_we;
    logic [3:0]  i_sel;
    logic        i_stb;
    logic        i_cyc;
    logic        o_ack;
    logic        i_tagn;
    logic        o_tagn;
    logic        o_irq;

    always #5 clk = ~clk;

    wishbone_timer_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .i_ADDR(i_addr),
        .i_DATA(i_data),
        .o_DATA(o_data),
        .i_WE  (i_we),
        .i_SEL (i_sel),
        .i_STB (i_stb),
        .i_CYC (i_cyc),
        .o_ACK (o_ack),
        .i_TAGN(i_tagn),
        .o_TAGN(o_tagn),
        .o_IRQ (o_irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    logic [31:0] m_ctrl, m_pre, m_cnt, m_cmp, m_ps, m_rdata;
    bit          m_match, m_ack, m_tagn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_pre = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ps = 0;
        m_match = 0; m_ack = 0; m_tagn = 0; m_rdata = 0;
    endtask

    function automatic logic [31:0] view(input int idx);
        case (idx)
            0: return m_ctrl;
            1: return m_pre;
            2: return m_cnt;
            3: return m_cmp;
            4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive the bus, advance the model, then compare everything visible.
    task automatic cycle(input bit cyc, input bit stb, input bit we, input int idx,
                         input logic [31:0] d, input logic [3:0] sel, input bit tag);
        bit acc, tick, set, clr, cnt_written;
        logic [31:0] wv, n_cnt, n_ps;
        i_cyc  = cyc;
        i_stb  = stb;
        i_we   = we;
        i_addr = (idx * 4) + $urandom_range(0, 3);
        i_data = d;
        i_sel  = sel;
        i_tagn = tag;

        acc  = cyc && stb && !m_ack;
        tick = m_ctrl[0] && (m_ps == m_pre);
        set = 0; clr = 0; cnt_written = 0;
        n_cnt = m_cnt;
        n_ps  = !m_ctrl[0] ? 0 : (tick ? 0 : m_ps + 1);
        if (tick) begin
            if (m_cnt == m_cmp) begin
                set   = 1;
                n_cnt = m_ctrl[1] ? 0 : m_cnt + 1;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        m_rdata = (acc && !we) ? view(idx) : 0;
        if (acc) m_tagn = tag;
        if (acc && we) begin
            wv = view(idx);
            for (int l = 0; l < 4; l++) if (sel[l]) wv[8*l +: 8] = d[8*l +: 8];
            case (idx)
                0: m_ctrl = wv & 32'h7;
                1: begin m_pre = wv & 32'hFFFF; n_ps = 0; end
                2: begin n_cnt = wv; cnt_written = 1; end
                3: m_cmp = wv;
                4: clr = sel[0] && d[0];
                default: ;
            endcase
        end
        if (cnt_written) set = 0;
        m_match = set ? 1 : (clr ? 0 : m_match);
        m_cnt = n_cnt;
        m_ps  = n_ps;
        m_ack = acc;

        @(posedge clk);
        #1;
        check("ack", o_ack, m_ack);
        check("rdata", o_data, m_rdata);
        check("irq", o_irq, m_match & m_ctrl[2]);
        check("tagn", o_tagn, m_tagn);
        check("count", dut.count_q, m_cnt);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 32'd0, 4'd0, 0);
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] sel);
        cycle(1, 1, 1, idx, d, sel, $urandom_range(0, 1));
        idle();
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        cycle(1, 1, 0, idx, 32'd0, 4'hF, $urandom_range(0, 1));
        d = o_data;
        idle();
    endtask

    logic [31:0] rv;

    initial begin
        rst = 1'b1;
        i_cyc = 0; i_stb = 0; i_we = 0; i_addr = 0; i_data = 0; i_sel = 0; i_tagn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", o_ack, 0);
        check("rst_data", o_data, 0);
        check("rst_irq", o_irq, 0);
        check("rst_tagn", o_tagn, 0);
        rst = 1'b0;
        rd(3, rv);
        check("rst_compare", rv, 32'hFFFF_FFFF);
        rd(0, rv);
        check("rst_ctrl", rv, 0);

        // Byte-lane write with strobe held three cycles: ack, gap, ack.
        cycle(1, 1, 1, 3, 32'hAABB_CCDD, 4'b0010, 1);
        check("hold_ack1", o_ack, 1);
        cycle(1, 1, 1, 3, 32'hAABB_CCDD, 4'b0010, 0);
        check("hold_ack2", o_ack, 0);
        cycle(1, 1, 1, 3, 32'hAABB_CCDD, 4'b0010, 0);
        check("hold_ack3", o_ack, 1);
        idle();
        check("hold_ack4", o_ack, 0);
        rd(3, rv);
        check("sel_compare", rv, 32'hFFFF_CCFF);

        // Autoreload at COMPARE=3, prescale 0.
        wr(3, 32'd3, 4'hF);
        wr(1, 32'd0, 4'hF);
        cycle(1, 1, 1, 0, 32'h7, 4'hF, 0);
        check("ar_cnt0", dut.count_q, 0);
        for (int k = 0; k < 5; k++) begin
            idle();
            check("ar_seq", dut.count_q, (k + 1) % 4);
            check("ar_irq", o_irq, (k >= 3) ? 1 : 0);
        end

        // STATUS read and W1C, then clear coincident with a match.
        wr(0, 32'h6, 4'hF);
        rd(4, rv);
        check("stat_read", rv, 1);
        wr(4, 32'h1, 4'h1);
        check("w1c_irq", o_irq, 0);
        rd(4, rv);
        check("w1c_stat", rv, 0);
        wr(2, 32'd3, 4'hF);
        cycle(1, 1, 1, 0, 32'h7, 4'hF, 0);
        cycle(1, 1, 1, 4, 32'h1, 4'h1, 0);
        check("w1c_vs_set", o_irq, 1);
        check("w1c_vs_set_m", dut.match_q, 1);
        wr(0, 32'h0, 4'hF);
        wr(4, 32'h1, 4'hF);

        // Prescale 4 without autoreload: one count every five cycles.
        wr(2, 32'd0, 4'hF);
        wr(3, 32'hFFFF_FFFF, 4'hF);
        wr(1, 32'd4, 4'hF);
        cycle(1, 1, 1, 0, 32'h1, 4'hF, 0);
        for (int k = 1; k <= 15; k++) begin
            idle();
            if (k == 4 || k == 5 || k == 10 || k == 15)
                check("ps4_count", dut.count_q, k / 5);
        end

        // Wrap from all-ones is not a match.
        wr(0, 32'h0, 4'hF);
        wr(2, 32'hFFFF_FFFF, 4'hF);
        wr(3, 32'h10, 4'hF);
        wr(1, 32'd0, 4'hF);
        cycle(1, 1, 1, 0, 32'h5, 4'hF, 0);
        idle();
        check("wrap_count", dut.count_q, 0);
        check("wrap_match", dut.match_q, 0);
        check("wrap_irq", o_irq, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int op, idx;
            logic [31:0] d;
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 7);
            case (idx)
                1: d = $urandom_range(0, 3);
                2: d = $urandom_range(0, 12);
                3: d = $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            if (op < 3) idle();
            else if (op < 7) cycle(1, 1, 1, idx, d, 4'($urandom_range(0, 15)), $urandom_range(0, 1));
            else cycle(1, 1, 0, idx, 32'd0, 4'hF, $urandom_range(0, 1));
        end
        idle();

        // Asynchronous reset mid-transfer while counting.
        wr(1, 32'd0, 4'hF);
        wr(0, 32'h7, 4'hF);
        cycle(1, 1, 0, 2, 32'd0, 4'hF, 1);
        check("pre_rst_ack", o_ack, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ack", o_ack, 0);
        check("arst_data", o_data, 0);
        check("arst_irq", o_irq, 0);
        check("arst_tagn", o_tagn, 0);
        check("arst_count", dut.count_q, 0);
        check("arst_compare", dut.compare_q, 32'hFFFF_FFFF);
        i_cyc = 0; i_stb = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rd(3, rv);
        check("post_rst_compare", rv, 32'hFFFF_FFFF);
        rd(0, rv);
        check("post_rst_ctrl", rv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
